// File: rtl/br_gshare_nextpc.sv
// Fetch-side next-PC selector with a gshare direction predictor.
// Lookup is combinational; training, history repair and perf counters update on clk.
module br_gshare_nextpc #(
   parameter int pht_index = 10,
   parameter int ghr_len   = 10,
   parameter int cnt_width = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 predict,
   input  logic [31:0]          pc_curr,
   input  logic [31:0]          btb_target,
   output logic [31:0]          pc_next,
   output logic                 pred_taken,
   output logic [ghr_len-1:0]   pred_ghr,
   input  logic                 update,
   input  logic [31:0]          pc_update,
   input  logic [ghr_len-1:0]   update_ghr,
   input  logic                 update_taken,
   input  logic                 mispredict,
   output logic [cnt_width-1:0] pred_count,
   output logic [cnt_width-1:0] mispred_count
);

   localparam int PHT_N = 1 << pht_index;
   localparam logic [cnt_width-1:0] CNT_ONE = {{(cnt_width-1){1'b0}}, 1'b1};

   logic [1:0]           pht_q [PHT_N];
   logic [ghr_len-1:0]   ghr_q, ghr_d;
   logic [cnt_width-1:0] pred_count_q, pred_count_d;
   logic [cnt_width-1:0] mispred_count_q, mispred_count_d;

   logic [pht_index-1:0] ghr_ext, upd_ghr_ext;
   logic [pht_index-1:0] ridx, widx;
   logic                 btb_hit;
   logic [1:0]           pht_cur, pht_nxt;

   // History is narrower than (or equal to) the index; zero-extend before the XOR.
   always_comb begin
      ghr_ext                   = '0;
      ghr_ext[ghr_len-1:0]      = ghr_q;
      upd_ghr_ext               = '0;
      upd_ghr_ext[ghr_len-1:0]  = update_ghr;
   end

   assign ridx       = pc_curr[pht_index+1:2] ^ ghr_ext;
   assign widx       = pc_update[pht_index+1:2] ^ upd_ghr_ext;
   assign btb_hit    = (btb_target != 32'd0);
   assign pred_taken = btb_hit & pht_q[ridx][1];
   assign pc_next    = pred_taken ? btb_target : pc_curr + 32'd4;
   assign pred_ghr   = ghr_q;

   assign pred_count    = pred_count_q;
   assign mispred_count = mispred_count_q;

   // Saturating 2-bit counter step for the entry being trained.
   always_comb begin
      pht_cur = pht_q[widx];
      pht_nxt = pht_cur;
      if (update_taken) begin
         if (pht_cur != 2'b11) pht_nxt = pht_cur + 2'b01;
      end else begin
         if (pht_cur != 2'b00) pht_nxt = pht_cur - 2'b01;
      end
   end

   // A mispredict repair wins over any speculative shift in the same cycle.
   always_comb begin
      ghr_d           = ghr_q;
      pred_count_d    = pred_count_q;
      mispred_count_d = mispred_count_q;
      if (update && mispredict) begin
         ghr_d = {update_ghr[ghr_len-2:0], update_taken};
      end else if (predict && btb_hit) begin
         ghr_d = {ghr_q[ghr_len-2:0], pred_taken};
      end
      if (predict && btb_hit) pred_count_d = pred_count_q + CNT_ONE;
      if (update && mispredict) mispred_count_d = mispred_count_q + CNT_ONE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < PHT_N; i++) pht_q[i] <= 2'b01;
         ghr_q           <= '0;
         pred_count_q    <= '0;
         mispred_count_q <= '0;
      end else begin
         if (update) pht_q[widx] <= pht_nxt;
         ghr_q           <= ghr_d;
         pred_count_q    <= pred_count_d;
         mispred_count_q <= mispred_count_d;
      end
   end

   logic unused_pc_bits;
   assign unused_pc_bits = ^{pc_curr[31:pht_index+2], pc_curr[1:0],
                             pc_update[31:pht_index+2], pc_update[1:0]};

endmodule

// File: tb/tb_br_gshare_nextpc.sv
// Directed-vector bench for br_gshare_nextpc with hand-computed expectations.
module tb_br_gshare_nextpc;

   logic        clk;
   logic        rst;
   logic        predict;
   logic [31:0] pc_curr;
   logic [31:0] btb_target;
   logic [31:0] pc_next;
   logic        pred_taken;
   logic [9:0]  pred_ghr;
   logic        update;
   logic [31:0] pc_update;
   logic [9:0]  update_ghr;
   logic        update_taken;
   logic        mispredict;
   logic [31:0] pred_count;
   logic [31:0] mispred_count;

   int checks   = 0;
   int failures = 0;

   br_gshare_nextpc #(.pht_index(10), .ghr_len(10), .cnt_width(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .predict      (predict),
      .pc_curr      (pc_curr),
      .btb_target   (btb_target),
      .pc_next      (pc_next),
      .pred_taken   (pred_taken),
      .pred_ghr     (pred_ghr),
      .update       (update),
      .pc_update    (pc_update),
      .update_ghr   (update_ghr),
      .update_taken (update_taken),
      .mispredict   (mispredict),
      .pred_count   (pred_count),
      .mispred_count(mispred_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end else begin
         $display("ok   %s = 0x%08h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_update(input logic u, input logic [31:0] pc, input logic [9:0] g,
                             input logic t, input logic m);
      update       = u;
      pc_update    = pc;
      update_ghr   = g;
      update_taken = t;
      mispredict   = m;
   endtask

   initial begin
      rst = 1'b1; predict = 1'b0; pc_curr = 32'h100; btb_target = 32'h0;
      set_update(1'b0, 32'h0, 10'h0, 1'b0, 1'b0);
      tick(); tick();
      rst = 1'b0;

      // Reset state, no BTB hit: fall-through and no history change.
      predict = 1'b1;
      #1;
      check_eq("rst_pc_next", pc_next, 32'h104);
      check_eq("rst_pred_taken", {31'b0, pred_taken}, 32'h0);
      check_eq("rst_pred_ghr", {22'b0, pred_ghr}, 32'h0);
      check_eq("rst_pred_count", pred_count, 32'h0);
      check_eq("rst_mispred_count", mispred_count, 32'h0);
      tick();
      check_eq("nohit_ghr", {22'b0, pred_ghr}, 32'h0);
      check_eq("nohit_pred_count", pred_count, 32'h0);

      // 32-bit wrap of the fall-through address.
      predict = 1'b0; pc_curr = 32'hFFFF_FFFC;
      #1;
      check_eq("wrap_pc_next", pc_next, 32'h0);

      // BTB hit, weakly not-taken entry 0x40: still falls through.
      pc_curr = 32'h100; btb_target = 32'h200;
      #1;
      check_eq("hit_wnt_taken", {31'b0, pred_taken}, 32'h0);
      check_eq("hit_wnt_pc_next", pc_next, 32'h104);

      // One taken training: 01 -> 10, now predicts taken.
      set_update(1'b1, 32'h100, 10'h0, 1'b1, 1'b0);
      tick();
      set_update(1'b0, 32'h0, 10'h0, 1'b0, 1'b0);
      #1;
      check_eq("train1_taken", {31'b0, pred_taken}, 32'h1);
      check_eq("train1_pc_next", pc_next, 32'h200);
      predict = 1'b1;
      tick();
      predict = 1'b0;
      check_eq("spec_shift_ghr", {22'b0, pred_ghr}, 32'h1);
      check_eq("spec_pred_count", pred_count, 32'h1);
      // GHR=1 now indexes entry 0x41 (still 01) for pc 0x100.
      check_eq("ghr_xor_taken", {31'b0, pred_taken}, 32'h0);

      // Saturation on entry 0x40, observed via pc 0x104 ^ GHR 1.
      pc_curr = 32'h104; btb_target = 32'h300;
      for (int i = 0; i < 4; i++) begin
         set_update(1'b1, 32'h100, 10'h0, 1'b1, 1'b0);
         tick();
      end
      check_eq("sat_hi_taken", {31'b0, pred_taken}, 32'h1);
      set_update(1'b1, 32'h100, 10'h0, 1'b0, 1'b0);
      tick();
      check_eq("sat_hi_dec_taken", {31'b0, pred_taken}, 32'h1);
      check_eq("sat_hi_dec_pc_next", pc_next, 32'h300);
      tick();
      check_eq("dec_01_taken", {31'b0, pred_taken}, 32'h0);
      tick();
      tick();
      set_update(1'b1, 32'h100, 10'h0, 1'b1, 1'b0);
      tick();
      check_eq("sat_lo_inc_taken", {31'b0, pred_taken}, 32'h0);
      tick();
      check_eq("sat_lo_inc2_taken", {31'b0, pred_taken}, 32'h1);

      // Recovery to 0b111 via mispredict (trains entry 0x203, unrelated).
      set_update(1'b1, 32'h800, 10'h3, 1'b1, 1'b1);
      tick();
      set_update(1'b0, 32'h0, 10'h0, 1'b0, 1'b0);
      check_eq("recov1_ghr", {22'b0, pred_ghr}, 32'h7);
      check_eq("recov1_mispred", mispred_count, 32'h1);

      // pc 0x11C ^ 7 -> entry 0x40 (10): predicted taken, hit + mispredict same cycle.
      pc_curr = 32'h11C; btb_target = 32'h400;
      #1;
      check_eq("pre_recov_taken", {31'b0, pred_taken}, 32'h1);
      predict = 1'b1;
      set_update(1'b1, 32'h900, 10'h2, 1'b0, 1'b1);
      tick();
      predict = 1'b0;
      set_update(1'b0, 32'h0, 10'h0, 1'b0, 1'b0);
      check_eq("recov2_ghr", {22'b0, pred_ghr}, 32'h4);
      check_eq("recov2_mispred", mispred_count, 32'h2);
      check_eq("recov2_pred_count", pred_count, 32'h2);

      // mispredict without update is ignored.
      mispredict = 1'b1;
      tick();
      mispredict = 1'b0;
      check_eq("orphan_mispred", mispred_count, 32'h2);
      check_eq("orphan_ghr", {22'b0, pred_ghr}, 32'h4);

      // Hit predicted not-taken shifts a zero into history.
      pc_curr = 32'h100; btb_target = 32'h200;
      predict = 1'b1;
      #1;
      check_eq("nt_hit_taken", {31'b0, pred_taken}, 32'h0);
      tick();
      predict = 1'b0;
      check_eq("nt_shift_ghr", {22'b0, pred_ghr}, 32'h8);
      check_eq("nt_shift_pred_count", pred_count, 32'h3);

      // Same-cycle train and lookup of entry 0x68 (pc 0x180 ^ GHR 8).
      pc_curr = 32'h180; btb_target = 32'h500;
      set_update(1'b1, 32'h180, 10'h8, 1'b1, 1'b0);
      #1;
      check_eq("samecyc_before", {31'b0, pred_taken}, 32'h0);
      tick();
      set_update(1'b0, 32'h0, 10'h0, 1'b0, 1'b0);
      check_eq("samecyc_after", {31'b0, pred_taken}, 32'h1);
      check_eq("samecyc_pc_next", pc_next, 32'h500);

      // Reset wins over simultaneous update and predict.
      rst = 1'b1; predict = 1'b1;
      set_update(1'b1, 32'h180, 10'h8, 1'b1, 1'b1);
      tick();
      rst = 1'b0; predict = 1'b0;
      set_update(1'b0, 32'h0, 10'h0, 1'b0, 1'b0);
      check_eq("rst2_ghr", {22'b0, pred_ghr}, 32'h0);
      check_eq("rst2_pred_count", pred_count, 32'h0);
      check_eq("rst2_mispred_count", mispred_count, 32'h0);
      pc_curr = 32'h100; btb_target = 32'h200;
      #1;
      check_eq("rst2_entry40", {31'b0, pred_taken}, 32'h0);
      pc_curr = 32'h1A0;
      #1;
      check_eq("rst2_entry68", {31'b0, pred_taken}, 32'h0);
      check_eq("rst2_pc_next", pc_next, 32'h1A4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
